// File: rtl/jtag_dr_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | jtag_dr_sequencer: USER4 DR scan sequencer, byte FIFO in, result out.     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module jtag_dr_sequencer #(
  parameter int RESULT_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    tck,
  input  logic                    rst_n,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic                    test_logic_reset,
  input  logic                    ir_is_user,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  output logic [7:0]              byte_data,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  input  logic [RESULT_WIDTH-1:0] result,
  input  logic                    result_valid,
  output logic [CNT_WIDTH-1:0]    bytes_accepted,
  output logic                    overflow,
  output logic                    bad_scan,
  output logic                    readback_done
);
  localparam int         c_aw     = $clog2(FIFO_DEPTH);
  localparam logic [7:0] c_rw_len = 8'(RESULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [7:0]              r_bit_cnt;
  logic [7:0]              r_in_sr;
  logic [RESULT_WIDTH-1:0] r_out_sr;
  logic                    w_cap;
  logic                    w_upd;
  logic                    w_shift;
  logic                    w_push;
  logic                    w_rb;
  logic                    w_bad;
  logic [c_aw:0]           r_wr_ptr;
  logic [c_aw:0]           r_rd_ptr;
  logic [7:0]              r_mem [FIFO_DEPTH];
  logic                    w_empty;
  logic                    w_full;
  logic                    w_pop;
  logic                    w_push_ok;
  logic                    w_drop;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_ovf;
  logic                    r_bad;
  logic                    r_rb;

  // Capture wins over update, update wins over shift; update only counts inside a scan.
  assign w_cap   = ir_is_user & capture_dr;
  assign w_upd   = ir_is_user & update_dr & ~capture_dr & (r_state == ST_SHIFT);
  assign w_shift = ir_is_user & shift_dr & ~capture_dr & ~update_dr & (r_state == ST_SHIFT);

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_rb        = 1'b0;
    w_bad       = 1'b0;
    if (w_cap) begin
      w_state_nxt = ST_SHIFT;
    end else if (w_upd) begin
      w_state_nxt = ST_UPDATE;
      if (r_bit_cnt == 8'd8)
        w_push = 1'b1;
      else if (r_bit_cnt >= c_rw_len)
        w_rb = 1'b1;
      else
        w_bad = 1'b1;
    end else if (r_state == ST_UPDATE) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n)
      r_state <= ST_IDLE;
    else if (test_logic_reset)
      r_state <= ST_IDLE;
    else
      r_state <= w_state_nxt;
  end

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]) && (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]);
  assign w_pop     = ~w_empty & byte_ready;
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign w_push_ok = w_push & (~w_full | w_pop) & ~test_logic_reset;
  assign w_drop    = w_push & w_full & ~w_pop;

  always_ff @(posedge tck or negedge rst_n) begin
    if (!rst_n) begin
      r_bit_cnt <= '0;
      r_in_sr   <= '0;
      r_out_sr  <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_bad     <= 1'b0;
      r_rb      <= 1'b0;
    end else if (test_logic_reset) begin
      r_bit_cnt <= '0;
      r_in_sr   <= '0;
      r_out_sr  <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_bad     <= 1'b0;
      r_rb      <= 1'b0;
    end else begin
      if (w_cap) begin
        r_bit_cnt <= '0;
        r_out_sr  <= result_valid ? result : '1;
      end else if (w_shift) begin
        r_in_sr  <= {tdi, r_in_sr[7:1]};
        r_out_sr <= {1'b0, r_out_sr[RESULT_WIDTH-1:1]};
        if (r_bit_cnt != 8'hFF)
          r_bit_cnt <= r_bit_cnt + 8'd1;
      end
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
        r_cnt    <= r_cnt + CNT_WIDTH'(1);
      end
      if (w_drop)
        r_ovf <= 1'b1;
      if (w_bad)
        r_bad <= 1'b1;
      r_rb <= w_rb;
    end
  end

  always_ff @(posedge tck) begin
    if (w_push_ok)
      r_mem[r_wr_ptr[c_aw-1:0]] <= r_in_sr;
  end

  assign tdo            = r_out_sr[0];
  assign byte_valid     = ~w_empty;
  assign byte_data      = w_empty ? 8'h00 : r_mem[r_rd_ptr[c_aw-1:0]];
  assign bytes_accepted = r_cnt;
  assign overflow       = r_ovf;
  assign bad_scan       = r_bad;
  assign readback_done  = r_rb;

endmodule
`default_nettype wire

// File: tb/tb_jtag_dr_sequencer.sv
`default_nettype none
// tb_jtag_dr_sequencer: random and directed scans checked against a queue-based model.
module tb_jtag_dr_sequencer;
  localparam int RW = 16;
  localparam int DEPTH = 4;
  localparam int CW = 32;

  logic tck = 1'b0, rst_n = 1'b0, tdi = 1'b0, tlr = 1'b0, ir = 1'b1;
  logic cap = 1'b0, sh = 1'b0, upd = 1'b0, ready = 1'b0, rvalid = 1'b0;
  logic [RW-1:0] res = '0;
  logic tdo, byte_valid, overflow, bad_scan, readback_done;
  logic [7:0] byte_data;
  logic [CW-1:0] bytes_accepted;

  jtag_dr_sequencer #(.RESULT_WIDTH(RW), .FIFO_DEPTH(DEPTH), .CNT_WIDTH(CW)) dut (
    .tck(tck), .rst_n(rst_n), .tdi(tdi), .tdo(tdo), .test_logic_reset(tlr),
    .ir_is_user(ir), .capture_dr(cap), .shift_dr(sh), .update_dr(upd),
    .byte_data(byte_data), .byte_valid(byte_valid), .byte_ready(ready),
    .result(res), .result_valid(rvalid), .bytes_accepted(bytes_accepted),
    .overflow(overflow), .bad_scan(bad_scan), .readback_done(readback_done));

  always #5 tck = ~tck;

  int n_chk = 0, n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference model: byte queue, counters and a record of what the current scan has seen.
  logic [7:0] m_q[$];
  int unsigned m_cnt;
  bit m_ovf, m_bad, m_rb, m_act;
  int m_bits, m_k;
  logic [7:0] m_in;
  logic [RW-1:0] m_v;
  bit rmode = 0;
  logic tdo_pre;
  logic [7:0] popped[$];
  int rb_cnt = 0;

  function automatic void m_clear();
    m_q.delete(); m_cnt = 0; m_ovf = 0; m_bad = 0; m_rb = 0; m_act = 0;
    m_bits = 0; m_k = 0; m_in = '0; m_v = '0;
  endfunction

  function automatic void m_edge(bit c, bit s, bit u, bit t, bit f);
    bit pop, full, push;
    if (f) begin m_clear(); return; end
    pop = (m_q.size() > 0) && ready;
    full = (m_q.size() == DEPTH);
    push = 0;
    m_rb = 0;
    if (ir && c) begin
      m_act = 1; m_bits = 0; m_k = 0; m_v = rvalid ? res : '1;
    end else if (ir && u && m_act) begin
      m_act = 0;
      if (m_bits == 8) push = 1;
      else if (m_bits >= RW) m_rb = 1;
      else m_bad = 1;
    end else if (ir && s && m_act) begin
      m_in = (m_in >> 1) | (t ? 8'h80 : 8'h00);
      if (m_bits < 255) m_bits++;
      m_k++;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (!full || pop) begin m_q.push_back(m_in); m_cnt++; end
      else m_ovf = 1;
    end
  endfunction

  task automatic check_outs();
    chk("byte_valid", byte_valid, (m_q.size() > 0));
    chk("byte_data", byte_data, (m_q.size() > 0) ? m_q[0] : 8'h00);
    chk("bytes_accepted", bytes_accepted, m_cnt);
    chk("overflow", overflow, m_ovf);
    chk("bad_scan", bad_scan, m_bad);
    chk("readback_done", readback_done, m_rb);
    chk("tdo", tdo, (m_k < RW) ? m_v[m_k] : 1'b0);
  endtask

  task automatic step(input bit c, input bit s, input bit u, input bit t, input bit f);
    @(negedge tck);
    cap = c; sh = s; upd = u; tdi = t; tlr = f;
    if (rmode) ready = 1'($urandom_range(0, 1));
    tdo_pre = tdo;
    if (byte_valid && ready) popped.push_back(byte_data);
    m_edge(c, s, u, t, f);
    @(posedge tck); #1;
    if (readback_done) rb_cnt++;
    check_outs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic flush();
    step(0, 0, 0, 0, 1);
  endtask

  task automatic scan_n(input int n, input logic [31:0] d);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) step(0, 1, 0, (i < 32) ? d[i] : 1'b0, 0);
    step(0, 0, 1, 0, 0);
  endtask

  task automatic readback(input int n, output logic [31:0] w);
    w = '0;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) begin
      step(0, 1, 0, 0, 0);
      if (i < 32) w[i] = tdo_pre;
    end
    step(0, 0, 1, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge tck); #2;
    rst_n = 1'b0; cap = 0; sh = 0; upd = 0; tdi = 0; tlr = 0;
    m_clear();
    #1 check_outs();
    @(negedge tck); rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w;
    logic [7:0] msg [4];
    int kind, len, cnt_before;
    msg[0] = 8'h4C; msg[1] = 8'h36; msg[2] = 8'h38; msg[3] = 8'h0A;
    m_clear();
    #1 check_outs();
    @(negedge tck); rst_n = 1'b1;
    idle(2);

    // Reset in the middle of a shift, then a clean byte.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 1'b1, 0);
    do_reset();
    scan_n(8, 32'h41);
    idle(1);
    chk("mid_rst_byte", byte_data, 8'h41);

    // Stream "L68\n" to an always-ready solver.
    flush();
    ready = 1'b1;
    popped.delete();
    for (int i = 0; i < 4; i++) begin scan_n(8, {24'h0, msg[i]}); idle(1); end
    idle(2);
    chk("l68_count", popped.size(), 4);
    for (int i = 0; i < 4 && i < popped.size(); i++) chk("l68_byte", popped[i], msg[i]);
    chk("l68_accepted", bytes_accepted, 4);

    // Overflow with a stalled solver, then drain.
    flush();
    ready = 1'b0;
    for (int i = 0; i < 6; i++) scan_n(8, 32'h10 + i);
    chk("ovf_flag", overflow, 1);
    chk("ovf_accepted", bytes_accepted, 4);
    popped.delete();
    ready = 1'b1;
    idle(8);
    chk("ovf_drain", popped.size(), 4);
    if (popped.size() == 4) chk("ovf_last", popped[3], 8'h13);

    // Push into a full FIFO in the same cycle as a pop.
    flush();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) scan_n(8, 32'h20 + i);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 0, w[i], 0);
    ready = 1'b1;
    step(0, 0, 1, 0, 0);
    ready = 1'b0;
    chk("pp_no_ovf", overflow, 0);
    chk("pp_accepted", bytes_accepted, 5);
    popped.delete();
    ready = 1'b1;
    idle(8);
    chk("pp_occupancy", popped.size(), 4);
    ready = 1'b0;

    // Result readback, valid and not valid.
    flush();
    res = 16'h0BEE; rvalid = 1'b1;
    rb_cnt = 0;
    readback(16, w);
    idle(2);
    chk("rb_value", w, 32'h0BEE);
    chk("rb_pulses", rb_cnt, 1);
    chk("rb_fifo", byte_valid, 0);
    rvalid = 1'b0;
    readback(16, w);
    idle(1);
    chk("rb_notready", w, 32'hFFFF);

    // Short scan flags, flush clears.
    scan_n(5, 32'h1F);
    idle(1);
    chk("bad_set", bad_scan, 1);
    flush();
    chk("bad_clear", bad_scan, 0);

    // DR events while IR is not USER4.
    cnt_before = bytes_accepted;
    ir = 1'b0;
    scan_n(8, 32'hA5);
    ir = 1'b1;
    idle(1);
    chk("ir_gate", bytes_accepted, cnt_before);

    // Randomized mix of scans against the model.
    rmode = 1;
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 7);
      rvalid = 1'($urandom_range(0, 1));
      res = RW'($urandom);
      ir = ($urandom_range(0, 9) != 0);
      case (kind)
        0, 1, 2: len = 8;
        3:       len = RW;
        4:       len = RW + $urandom_range(1, 5);
        5:       len = $urandom_range(0, 7);
        default: len = -1;
      endcase
      if (kind == 7) flush();
      else if (len >= 0) scan_n(len, $urandom);
      else begin
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 1'($urandom), 0);
      end
      idle($urandom_range(0, 3));
    end
    ir = 1'b1;
    rmode = 0;
    ready = 1'b1;
    idle(6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
